// File: rtl/fractal_sync_neighbor_mc_if.sv
// Request/response bundle of the multi-port fractal_sync neighbour node.
// Flat per-port vectors: port p occupies slice [p*W +: W].
interface fractal_sync_neighbor_mc_if #(
    parameter int unsigned N_PORTS = 2,
    parameter int unsigned ID_W    = 4
);
    logic [N_PORTS-1:0]      sync_i;
    logic [N_PORTS*ID_W-1:0] id_i;
    logic [N_PORTS-1:0]      wake_o;
    logic [N_PORTS*ID_W-1:0] rsp_id_o;
    logic [N_PORTS-1:0]      error_o;
    logic [N_PORTS*2-1:0]    err_code_o;
    logic                    busy_o;

    modport master (
        output sync_i, id_i,
        input  wake_o, rsp_id_o, error_o, err_code_o, busy_o
    );

    modport slave (
        input  sync_i, id_i,
        output wake_o, rsp_id_o, error_o, err_code_o, busy_o
    );
endinterface

// File: rtl/fractal_sync_neighbor_mc.sv
// Multi-port, multi-barrier-ID neighbour synchronisation node: wakes all ports when every
// port is pending on the same ID, otherwise reports mismatch, double request or timeout.
module fractal_sync_neighbor_mc #(
    parameter int unsigned N_PORTS   = 2,
    parameter int unsigned ID_W      = 4,
    parameter int unsigned TIMEOUT_W = 16,
    parameter int unsigned TIMEOUT   = 0,
    parameter int unsigned COMB      = 0
) (
    input logic                        clk_i,
    input logic                        rst_ni,
    fractal_sync_neighbor_mc_if.slave  bus
);
    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_DOUBLE   = 2'b01,
        ERR_MISMATCH = 2'b10,
        ERR_TIMEOUT  = 2'b11
    } err_code_e;

    localparam bit                   UseComb = (COMB != 0);
    localparam bit                   UseTmo  = (TIMEOUT != 0);
    localparam logic [TIMEOUT_W-1:0] TmoLast = TIMEOUT_W'(TIMEOUT - 1);

    if (N_PORTS < 2) begin : g_chk_ports
        $error("fractal_sync_neighbor_mc: N_PORTS must be >= 2");
    end
    if ((64'(TIMEOUT) >> TIMEOUT_W) != 64'd0) begin : g_chk_tmo
        $error("fractal_sync_neighbor_mc: TIMEOUT does not fit in TIMEOUT_W bits");
    end

    logic [N_PORTS-1:0]      pending_q, pending_d, accept, s_pending;
    logic [N_PORTS-1:0]      dbl_now, dbl_q, dbl_d, dbl_eval;
    logic [ID_W-1:0]         id_in    [N_PORTS];
    logic [ID_W-1:0]         s_id     [N_PORTS];
    logic [ID_W-1:0]         id_q     [N_PORTS];
    logic [ID_W-1:0]         id_d     [N_PORTS];
    logic [ID_W-1:0]         dbl_id_q [N_PORTS];
    logic [ID_W-1:0]         dbl_id_d [N_PORTS];
    logic [TIMEOUT_W-1:0]    cnt_q, cnt_d;
    logic                    busy, ids_eq, all_pend, complete, mismatch, tmo, evt;
    logic [N_PORTS-1:0]      wake, error;
    logic [N_PORTS*ID_W-1:0] rsp_id;
    logic [N_PORTS*2-1:0]    err_code;

    always_comb begin : eval
        busy   = |pending_q;
        accept = bus.sync_i & ~pending_q;
        for (int unsigned p = 0; p < N_PORTS; p++) begin
            id_in[p] = bus.id_i[p*ID_W +: ID_W];
            s_id[p]  = (UseComb && accept[p]) ? id_in[p] : id_q[p];
        end
        s_pending = UseComb ? (pending_q | accept) : pending_q;
        ids_eq = 1'b1;
        for (int unsigned p = 1; p < N_PORTS; p++) begin
            if (s_id[p] != s_id[0]) ids_eq = 1'b0;
        end
        all_pend = &s_pending;
        complete = all_pend & ids_eq;
        mismatch = all_pend & ~ids_eq;
        tmo      = UseTmo && busy && (cnt_q == TmoLast) && !all_pend;
        evt      = all_pend | tmo;
        // With registered evaluation, a repeat sync in the event cycle opens a new epoch
        dbl_now = bus.sync_i & pending_q;
        if (!UseComb && evt) dbl_now = '0;
    end

    always_comb begin : next_state
        pending_d = pending_q | accept;
        dbl_d     = UseComb ? '0 : dbl_now;
        cnt_d     = cnt_q;
        for (int unsigned p = 0; p < N_PORTS; p++) begin
            id_d[p]     = accept[p] ? id_in[p] : id_q[p];
            dbl_id_d[p] = id_in[p];
        end
        if (evt) begin
            pending_d = UseComb ? '0 : bus.sync_i;
            for (int unsigned p = 0; p < N_PORTS; p++) begin
                id_d[p] = (!UseComb && bus.sync_i[p]) ? id_in[p] : id_q[p];
            end
        end
        if (!busy || evt) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin : outputs
        wake     = '0;
        error    = '0;
        rsp_id   = '0;
        err_code = '0;
        dbl_eval = UseComb ? dbl_now : dbl_q;
        if (rst_ni) begin
            for (int unsigned p = 0; p < N_PORTS; p++) begin
                if (complete) begin
                    wake[p]                   = 1'b1;
                    rsp_id[p*ID_W +: ID_W]    = s_id[0];
                end else if (mismatch) begin
                    error[p]                  = 1'b1;
                    err_code[2*p +: 2]        = ERR_MISMATCH;
                    rsp_id[p*ID_W +: ID_W]    = s_id[p];
                end else if (tmo && s_pending[p]) begin
                    error[p]                  = 1'b1;
                    err_code[2*p +: 2]        = ERR_TIMEOUT;
                    rsp_id[p*ID_W +: ID_W]    = s_id[p];
                end else if (dbl_eval[p]) begin
                    error[p]                  = 1'b1;
                    err_code[2*p +: 2]        = ERR_DOUBLE;
                    rsp_id[p*ID_W +: ID_W]    = UseComb ? id_in[p] : dbl_id_q[p];
                end
            end
        end
    end

    assign bus.wake_o     = wake;
    assign bus.error_o    = error;
    assign bus.rsp_id_o   = rsp_id;
    assign bus.err_code_o = err_code;
    assign bus.busy_o     = busy;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= '0;
            dbl_q     <= '0;
            cnt_q     <= '0;
            for (int unsigned p = 0; p < N_PORTS; p++) begin
                id_q[p]     <= '0;
                dbl_id_q[p] <= '0;
            end
        end else begin
            pending_q <= pending_d;
            dbl_q     <= dbl_d;
            cnt_q     <= cnt_d;
            for (int unsigned p = 0; p < N_PORTS; p++) begin
                id_q[p]     <= id_d[p];
                dbl_id_q[p] <= dbl_id_d[p];
            end
        end
    end
endmodule

// File: tb/tb_fractal_sync_neighbor_mc.sv
// Scoreboard bench for fractal_sync_neighbor_mc: three configurations (registered/timeout,
// same-cycle, four-port), expected responses queued at stimulus time and matched on output.
module tb_fractal_sync_neighbor_mc;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fractal_sync_neighbor_mc_if #(.N_PORTS(2), .ID_W(4)) bus0 ();
    fractal_sync_neighbor_mc_if #(.N_PORTS(2), .ID_W(4)) bus1 ();
    fractal_sync_neighbor_mc_if #(.N_PORTS(4), .ID_W(4)) bus2 ();

    fractal_sync_neighbor_mc #(.N_PORTS(2), .ID_W(4), .TIMEOUT_W(16), .TIMEOUT(8), .COMB(0))
        u_reg (.clk_i(clk), .rst_ni(rst_n), .bus(bus0));
    fractal_sync_neighbor_mc #(.N_PORTS(2), .ID_W(4), .TIMEOUT_W(16), .TIMEOUT(0), .COMB(1))
        u_comb (.clk_i(clk), .rst_ni(rst_n), .bus(bus1));
    fractal_sync_neighbor_mc #(.N_PORTS(4), .ID_W(4), .TIMEOUT_W(16), .TIMEOUT(0), .COMB(0))
        u_quad (.clk_i(clk), .rst_ni(rst_n), .bus(bus2));

    typedef struct {
        int          inst;
        int          cyc;
        logic [3:0]  wake;
        logic [3:0]  err;
        logic [15:0] rsp;
        logic [7:0]  code;
    } exp_t;

    exp_t sb[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int inst, input int c, input logic [3:0] w, input logic [3:0] e,
                        input logic [15:0] r, input logic [7:0] code);
        exp_t x;
        x.inst = inst; x.cyc = c; x.wake = w; x.err = e; x.rsp = r; x.code = code;
        sb.push_back(x);
    endtask

    task automatic mon(input int inst, input logic [3:0] w, input logic [3:0] e,
                       input logic [15:0] r, input logic [7:0] c);
        int   idx;
        exp_t x;
        if ((w | e) != 4'd0) begin
            idx = -1;
            foreach (sb[i]) if (idx < 0 && sb[i].inst == inst) idx = i;
            if (idx < 0) begin
                check_eq($sformatf("unexpected_out_i%0d", inst), {w, e}, 64'd0);
            end else begin
                x = sb[idx];
                sb.delete(idx);
                check_eq($sformatf("resp_cycle_i%0d", inst), 64'(cyc), 64'(x.cyc));
                check_eq($sformatf("wake_i%0d", inst), 64'(w), 64'(x.wake));
                check_eq($sformatf("error_i%0d", inst), 64'(e), 64'(x.err));
                check_eq($sformatf("rsp_id_i%0d", inst), 64'(r), 64'(x.rsp));
                check_eq($sformatf("err_code_i%0d", inst), 64'(c), 64'(x.code));
            end
        end else begin
            check_eq($sformatf("idle_rsp_i%0d", inst), {r, c}, 64'd0);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, 4'(bus0.wake_o), 4'(bus0.error_o), 16'(bus0.rsp_id_o), 8'(bus0.err_code_o));
            mon(1, 4'(bus1.wake_o), 4'(bus1.error_o), 16'(bus1.rsp_id_o), 8'(bus1.err_code_o));
            mon(2, bus2.wake_o, bus2.error_o, bus2.rsp_id_o, bus2.err_code_o);
        end
    end

    task automatic zero_inputs();
        bus0.sync_i = '0; bus0.id_i = '0;
        bus1.sync_i = '0; bus1.id_i = '0;
        bus2.sync_i = '0; bus2.id_i = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        zero_inputs();
    endtask

    task automatic req(input int inst, input int p, input logic [3:0] id);
        case (inst)
            0: begin bus0.sync_i[p] = 1'b1; bus0.id_i[p*4 +: 4] = id; end
            1: begin bus1.sync_i[p] = 1'b1; bus1.id_i[p*4 +: 4] = id; end
            default: begin bus2.sync_i[p] = 1'b1; bus2.id_i[p*4 +: 4] = id; end
        endcase
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        zero_inputs();
        #12;
        check_eq("rst_wake", {bus0.wake_o, bus1.wake_o, bus2.wake_o}, 64'd0);
        check_eq("rst_error", {bus0.error_o, bus1.error_o, bus2.error_o}, 64'd0);
        check_eq("rst_busy", {bus0.busy_o, bus1.busy_o, bus2.busy_o}, 64'd0);
        check_eq("rst_rsp", {bus0.rsp_id_o, bus2.rsp_id_o}, 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) step();

        // Registered node: basic completion
        step(); t = cyc; req(0, 0, 4'd3);
        push(0, t + 3, 4'b0011, 4'b0000, 16'h0033, 8'h00);
        step(); step(); req(0, 1, 4'd3);
        step(); check_eq("reg_busy_wake_cycle", 64'(bus0.busy_o), 64'd1);
        step(); check_eq("reg_busy_after_wake", 64'(bus0.busy_o), 64'd0);

        // Registered node: double request, then the original barrier still completes
        step(); t = cyc; req(0, 0, 4'd7);
        step(); req(0, 0, 4'd7);
        push(0, t + 2, 4'b0000, 4'b0001, 16'h0007, 8'h01);
        step(); step(); req(0, 1, 4'd7);
        push(0, t + 4, 4'b0011, 4'b0000, 16'h0077, 8'h00);
        step(); step(); check_eq("reg_busy_after_double", 64'(bus0.busy_o), 64'd0);

        // Registered node: timeout after 8 cycles
        step(); t = cyc; req(0, 0, 4'd9);
        push(0, t + 8, 4'b0000, 4'b0001, 16'h0009, 8'h03);
        repeat (7) step();
        check_eq("tmo_busy_before", 64'(bus0.busy_o), 64'd1);
        step(); step();
        check_eq("tmo_busy_after", 64'(bus0.busy_o), 64'd0);

        // Registered node: request in the wake cycle starts a new epoch
        step(); t = cyc; req(0, 0, 4'd2);
        step(); req(0, 1, 4'd2);
        step(); req(0, 0, 4'd1);
        push(0, t + 2, 4'b0011, 4'b0000, 16'h0022, 8'h00);
        step(); check_eq("epoch_busy", 64'(bus0.busy_o), 64'd1); req(0, 1, 4'd1);
        push(0, t + 4, 4'b0011, 4'b0000, 16'h0011, 8'h00);
        step(); step(); check_eq("epoch_busy_after", 64'(bus0.busy_o), 64'd0);

        // Same-cycle node: completion, double request, mismatch
        step(); t = cyc; req(1, 0, 4'd5); req(1, 1, 4'd5);
        push(1, t, 4'b0011, 4'b0000, 16'h0055, 8'h00);
        step(); check_eq("comb_nothing_stored", 64'(bus1.busy_o), 64'd0);
        step(); t = cyc; req(1, 0, 4'd4);
        step(); req(1, 0, 4'd6);
        push(1, t + 1, 4'b0000, 4'b0001, 16'h0006, 8'h01);
        step(); req(1, 1, 4'd4);
        push(1, t + 2, 4'b0011, 4'b0000, 16'h0044, 8'h00);
        step(); check_eq("comb_busy_after_double", 64'(bus1.busy_o), 64'd0);
        step(); t = cyc; req(1, 0, 4'd1);
        step(); req(1, 1, 4'd2);
        push(1, t + 1, 4'b0000, 4'b0011, 16'h0021, 8'b0000_1010);
        step(); check_eq("comb_busy_after_mismatch", 64'(bus1.busy_o), 64'd0);

        // Four-port node: staggered mismatch, then simultaneous completion
        step(); t = cyc; req(2, 0, 4'd1);
        step(); req(2, 1, 4'd1);
        step(); req(2, 2, 4'd1);
        step(); req(2, 3, 4'd2);
        push(2, t + 4, 4'b0000, 4'b1111, 16'h2111, 8'hAA);
        step(); step(); check_eq("quad_busy_after_mismatch", 64'(bus2.busy_o), 64'd0);
        step(); t = cyc;
        for (int p = 0; p < 4; p++) req(2, p, 4'd6);
        push(2, t + 1, 4'b1111, 4'b0000, 16'h6666, 8'h00);
        step(); step(); check_eq("quad_busy_after_wake", 64'(bus2.busy_o), 64'd0);

        // Registered node: reset while a new-epoch request is pending
        step(); t = cyc; req(0, 0, 4'd2); req(0, 1, 4'd2);
        push(0, t + 1, 4'b0011, 4'b0000, 16'h0022, 8'h00);
        step(); req(0, 0, 4'd1);
        step(); check_eq("pre_reset_busy", 64'(bus0.busy_o), 64'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_reset_busy", 64'(bus0.busy_o), 64'd0);
        check_eq("mid_reset_out", {bus0.wake_o, bus0.error_o, bus0.rsp_id_o}, 64'd0);
        step(); rst_n = 1'b1;
        step(); t = cyc; req(0, 1, 4'd1);
        push(0, t + 8, 4'b0000, 4'b0010, 16'h0010, 8'b0000_1100);
        repeat (9) step();
        check_eq("post_reset_busy", 64'(bus0.busy_o), 64'd0);

        repeat (2) step();
        check_eq("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
